// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch-queue bus bundle: instruction memory side, CPU side and redirect
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with credit-limited fetch and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;     // pc belonging to the next non-stale response
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic drop;

  // Request only while every outstanding response, stale ones included, has a guaranteed slot
  always_comb begin
    bus.imem_req  = !reset && ((int'(occupancy) + int'(inflight) + int'(discard)) < DEPTH);
    bus.imem_addr = fetch_pc;
    accept        = bus.imem_req && bus.imem_ready;
    drop          = bus.imem_rvalid && (discard != '0);
    push          = bus.imem_rvalid && (discard == '0) && !bus.redirect;
    bus.instr_valid = !reset && (occupancy != '0);
    pop           = bus.instr_valid && bus.instr_ready;
    bus.instr_data = bus.instr_valid ? data_mem[rd_ptr] : 32'h0;
    bus.instr_pc   = bus.instr_valid ? pc_mem[rd_ptr]   : 32'h0;
  end

  // Fetch pointer, response tracking and FIFO bookkeeping; redirect overrides push and pop
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      occupancy <= '0;
      inflight  <= '0;
      discard   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (bus.redirect) begin
      fetch_pc  <= bus.redirect_pc & 32'hFFFF_FFFC;
      resp_pc   <= bus.redirect_pc & 32'hFFFF_FFFC;
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= '0;
      // Everything outstanding becomes stale; a response arriving now retires one of them
      discard   <= discard + inflight + CW'(accept) - CW'(bus.imem_rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CW'(push) - CW'(pop);
      inflight  <= inflight + CW'(accept) - CW'(push);
      discard   <= discard - CW'(drop);
    end
  end

  // FIFO storage: returned word together with the address it was fetched from
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed vector bench for ifetch_queue
module tb_ifetch_queue;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ifetch_queue_if bus ();
  ifetch_queue_if wbus ();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .bus(wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ird;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] idata;
    logic [31:0] ipc;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] wrap_exp [3];

  logic        pend;
  logic [31:0] pend_addr;
  int          n_acc;
  logic [31:0] last_acc;
  bit          seen;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic ird, input logic redir, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input logic iv,
                              input logic [31:0] idata, input logic [31:0] ipc);
    vec_t v;
    v = '{rdy, rv, rdata, ird, redir, rpc, req, addr, iv, idata, ipc};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of a memory that answers every accepted request exactly one cycle later
  task automatic step(input logic rdy, input logic ird, input logic redir, input logic [31:0] rpc);
    logic acc_now;
    @(negedge clk);
    bus.imem_ready  = rdy;
    bus.instr_ready = ird;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_rvalid = pend;
    bus.imem_rdata  = pend_addr ^ K;
    #1;
    acc_now   = bus.imem_req && rdy;
    pend      = acc_now;
    pend_addr = bus.imem_addr;
    if (acc_now) begin
      n_acc++;
      last_acc = bus.imem_addr;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pend = 1'b0; pend_addr = '0; n_acc = 0; last_acc = '0; seen = 1'b0;
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    wbus.imem_ready = 1'b1; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = '0;
    wbus.instr_ready = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = '0;

    // streaming fill, then redirect with three requests in flight and three stale responses
    tbl[0]  = mk(1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h000, 0, 32'h0,         32'h0);
    tbl[1]  = mk(1, 1, 32'hD000_0000, 1, 0, 32'h0,   1, 32'h004, 0, 32'h0,         32'h0);
    tbl[2]  = mk(1, 1, 32'hD000_0004, 1, 0, 32'h0,   1, 32'h008, 1, 32'hD000_0000, 32'h000);
    tbl[3]  = mk(1, 1, 32'hD000_0008, 1, 0, 32'h0,   1, 32'h00C, 1, 32'hD000_0004, 32'h004);
    tbl[4]  = mk(1, 1, 32'hD000_000C, 1, 0, 32'h0,   1, 32'h010, 1, 32'hD000_0008, 32'h008);
    tbl[5]  = mk(1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h014, 1, 32'hD000_000C, 32'h00C);
    tbl[6]  = mk(1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h018, 0, 32'h0,         32'h0);
    tbl[7]  = mk(0, 0, 32'h0,         1, 1, 32'h103, 1, 32'h01C, 0, 32'h0,         32'h0);
    tbl[8]  = mk(1, 1, 32'hBAD0_0010, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,         32'h0);
    tbl[9]  = mk(1, 1, 32'hBAD0_0014, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0,         32'h0);
    tbl[10] = mk(1, 1, 32'hBAD0_0018, 1, 0, 32'h0,   1, 32'h108, 0, 32'h0,         32'h0);
    tbl[11] = mk(0, 1, 32'hD000_0100, 1, 0, 32'h0,   1, 32'h10C, 0, 32'h0,         32'h0);
    tbl[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h10C, 1, 32'hD000_0100, 32'h100);
    tbl[13] = mk(0, 1, 32'hD000_0104, 1, 0, 32'h0,   1, 32'h10C, 1, 32'hD000_0100, 32'h100);
    tbl[14] = mk(0, 1, 32'hD000_0108, 1, 0, 32'h0,   1, 32'h10C, 1, 32'hD000_0104, 32'h104);
    tbl[15] = mk(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h10C, 1, 32'hD000_0108, 32'h108);
    tbl[16] = mk(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,         32'h0);
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",     {31'b0, bus.imem_req},    32'h0);
    chk("rst_valid",   {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_data",    bus.instr_data,           32'h0);
    chk("rst_pc",      bus.instr_pc,             32'h0);
    chk("rst_wrap_req", {31'b0, wbus.imem_req},  32'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      bus.imem_ready  = tbl[i].rdy;
      bus.imem_rvalid = tbl[i].rv;
      bus.imem_rdata  = tbl[i].rdata;
      bus.instr_ready = tbl[i].ird;
      bus.redirect    = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i),   {31'b0, bus.imem_req},    {31'b0, tbl[i].req});
      chk($sformatf("v%0d_addr", i),  bus.imem_addr,            tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, tbl[i].iv});
      chk($sformatf("v%0d_data", i),  bus.instr_data,           tbl[i].idata);
      chk($sformatf("v%0d_pc", i),    bus.instr_pc,             tbl[i].ipc);
      if (i < 3) chk($sformatf("wrap%0d_addr", i), wbus.imem_addr, wrap_exp[i]);
    end

    // backpressure from a fresh reset: exactly four fetches, then one per pop
    @(negedge clk);
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pend = 1'b0; n_acc = 0;
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_accepts",  n_acc,                    32'd4);
    chk("bp_last",     last_acc,                 32'h00C);
    chk("bp_req_off",  {31'b0, bus.imem_req},    32'h0);
    chk("bp_valid",    {31'b0, bus.instr_valid}, 32'h1);
    chk("bp_head_pc",  bus.instr_pc,             32'h000);
    chk("bp_head_dat", bus.instr_data,           32'h000 ^ K);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_refill_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("bp_refill_addr", bus.imem_addr,         32'h010);
    chk("bp_head_next",   bus.instr_pc,          32'h004);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_req",   {31'b0, bus.imem_req},    32'h0);
    chk("full_valid", {31'b0, bus.instr_valid}, 32'h1);

    // reset with the FIFO full
    @(negedge clk);
    reset = 1'b1;
    pend = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.instr_ready = 1'b0;
    #1;
    chk("mrst_req",   {31'b0, bus.imem_req},    32'h0);
    chk("mrst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("mrst_data",  bus.instr_data,           32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req",   {31'b0, bus.imem_req},    32'h1);
    chk("post_rst_addr",  bus.imem_addr,            32'h000);
    chk("post_rst_valid", {31'b0, bus.instr_valid}, 32'h0);

    // redirect in the same cycle as an acceptance and a response
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0202);
    chk("co_rv_seen", {31'b0, bus.imem_rvalid}, 32'h1);
    chk("co_acc_addr", bus.imem_addr,           32'h004);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("co_req",   {31'b0, bus.imem_req},    32'h1);
    chk("co_addr",  bus.imem_addr,            32'h200);
    chk("co_valid", {31'b0, bus.instr_valid}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (bus.instr_valid) begin
        seen = 1'b1;
        chk("co_first_pc",   bus.instr_pc,   32'h200);
        chk("co_first_data", bus.instr_data, 32'h200 ^ K);
      end
    end
    chk("co_valid_seen", {31'b0, seen}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: word-aligned fetch address; bits [1:0] always 0.
REQ-007 SHALL have port imem_ready, input, 1: memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1: read data returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rdata, input, 32: returned instruction word.
REQ-010 SHALL have port instr_valid, output, 1: head FIFO entry valid toward the CPU.
REQ-011 SHALL have port instr_data, output, 32: head instruction word.
REQ-012 SHALL have port instr_pc, output, 32: address of the head instruction.
REQ-013 SHALL have port instr_ready, input, 1: CPU consumes the head entry.
REQ-014 SHALL have port redirect, input, 1: branch or jump taken; flush and refetch.
REQ-015 SHALL have port redirect_pc, input, 32: new fetch address; bits [1:0] ignored and forced to 0.

Function
REQ-016 SHALL treat a request as accepted in any cycle with imem_req & imem_ready; imem_addr SHALL stay stable while imem_req is high and not accepted.
REQ-017 SHALL advance the fetch PC by 4 on each acceptance; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-018 SHALL keep inflight, the count of accepted requests not yet answered, range 0..DEPTH.
REQ-019 SHALL assert imem_req only when occupancy + inflight < DEPTH and not in reset, so a returned response always finds a free FIFO slot.
REQ-020 SHALL write {imem_rdata, pc of that request} into the FIFO on imem_rvalid unless the response is stale (REQ-024).
REQ-021 SHALL present the FIFO head registered: instr_valid rises no earlier than the cycle after the matching imem_rvalid.
REQ-022 SHALL pop the head on instr_valid & instr_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-023 SHALL hold instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL, on redirect, in the same edge: empty the FIFO, set fetch PC to {redirect_pc[31:2],2'b00}, set discard count to inflight + (request accepted this cycle) - (imem_rvalid this cycle), and set inflight to 0.
REQ-025 SHALL drop, without FIFO write, each imem_rvalid response while discard count > 0, decrementing the count; such responses SHALL not count toward occupancy + inflight credit but SHALL be included by counting discard in the REQ-019 limit (occupancy + inflight + discard < DEPTH).
REQ-026 SHALL issue the first post-redirect request no earlier than the cycle after redirect; instr_valid SHALL be 0 in the cycle after redirect.
REQ-027 SHALL give redirect priority over a simultaneous pop or push; a pop in the redirect cycle SHALL still count as consumed by the CPU.
REQ-028 SHALL handle a second redirect while discards are pending by adding the new in-flight requests to the remaining discard count.

Reset
REQ-029 SHALL, while reset=1, drive imem_req=0, instr_valid=0, instr_data=0, instr_pc=0, and set fetch PC=RESET_PC, occupancy=0, inflight=0, discard=0.
REQ-030 SHALL ignore imem_rvalid during reset and discard nothing afterwards; in-flight requests at reset are the memory's responsibility.
REQ-031 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.

Verification
REQ-032 SHALL cover streaming: imem_ready=1, rvalid 1 cycle after accept, instr_ready=1 -> instr_pc 0,4,8,12,... one per cycle after 2-cycle fill, data matches memory.
REQ-033 SHALL cover backpressure: instr_ready=0 -> exactly DEPTH=4 requests accepted (addrs 0..12), imem_req then 0, FIFO full; instr_ready=1 -> one new request per pop.
REQ-034 SHALL cover redirect with 3 in flight: redirect_pc=32'h0000_0103 -> next imem_addr=32'h0000_0100, 3 stale responses dropped, first instr_pc after redirect =32'h100.
REQ-035 SHALL cover wrap: RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL cover reset mid-stream with FIFO full -> next cycle instr_valid=0, imem_req=0; after deassert imem_addr=RESET_PC.
REQ-037 SHALL cover redirect coincident with acceptance and rvalid -> discard count = inflight+1-1, no stale word reaches instr_data.
